// File: rtl/hd44780_pkg.sv
`default_nettype none
//============================================================================
// Module : hd44780_pkg
// Brief  : Opcodes, DDRAM geometry, state types and AC wrap helper.
// Rev    : 1.0  initial release
//============================================================================
package hd44780_pkg;

  localparam int unsigned DDRAM_DEPTH = 128;
  localparam int unsigned DDRAM_AW    = 7;
  localparam logic [7:0]  BLANK_CHAR  = 8'h20;
  localparam logic [6:0]  SWEEP_LAST  = 7'(DDRAM_DEPTH - 1);

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_ADDR   = 7'h00;
  localparam logic [6:0] LINE2_ADDR   = 7'h40;
  localparam logic [6:0] LINE3_ADDR   = 7'h14;
  localparam logic [6:0] LINE4_ADDR   = 7'h54;
  localparam logic [6:0] LINE1_END    = 7'h27;
  localparam logic [6:0] LINE2_END    = 7'h67;
  localparam logic [6:0] ONE_LINE_END = 7'h4F;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} sweep_state_t;

  typedef enum logic [3:0] {
    INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISPLAY,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } ins_t;

  typedef struct packed {
    logic       four_bit;
    logic       phase_lo;
    logic       func_n;
    logic       display_on;
    logic       cursor_on;
    logic       blink;
    logic       entry_id;
    logic       entry_s;
    logic       cg_mode;
    logic [6:0] ac;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{entry_id: 1'b1, ac: 7'h00, default: 1'b0};

  // Instruction class is chosen by the highest set bit of the byte.
  function automatic ins_t decode_ins(input logic [7:0] b);
    if ((b & OP_DDRAM)   != 8'h00) return INS_DDRAM;
    if ((b & OP_CGRAM)   != 8'h00) return INS_CGRAM;
    if ((b & OP_FUNC)    != 8'h00) return INS_FUNC;
    if ((b & OP_SHIFT)   != 8'h00) return INS_SHIFT;
    if ((b & OP_DISPLAY) != 8'h00) return INS_DISPLAY;
    if ((b & OP_ENTRY)   != 8'h00) return INS_ENTRY;
    if ((b & OP_HOME)    != 8'h00) return INS_HOME;
    if ((b & OP_CLEAR)   != 8'h00) return INS_CLEAR;
    return INS_NOP;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                         input logic two_line);
    logic [6:0] r;
    r = inc ? a + 7'd1 : a - 7'd1;
    if (two_line) begin
      if (inc && a == LINE1_END)       r = LINE2_ADDR;
      else if (inc && a == LINE2_END)  r = LINE1_ADDR;
      else if (!inc && a == LINE2_ADDR) r = LINE1_END;
      else if (!inc && a == LINE1_ADDR) r = LINE2_END;
    end else begin
      if (inc && a == ONE_LINE_END)     r = LINE1_ADDR;
      else if (!inc && a == LINE1_ADDR) r = ONE_LINE_END;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hd44780_ddram.sv
`default_nettype none
//============================================================================
// Module : hd44780_ddram
// Brief  : 128x8 display RAM, one synchronous write port, registered read.
// Rev    : 1.0  initial release
//============================================================================
module hd44780_ddram
  import hd44780_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [DDRAM_AW-1:0] wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [DDRAM_AW-1:0] rd_addr,
  output logic [7:0]          rd_data
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/hd44780_responder.sv
`default_nettype none
//============================================================================
// Module : hd44780_responder
// Brief  : HD44780 display-side model of the 4-bit E/RS/DB bus.
// Config : HD44780_RSP_BUSY_TIMING_EN enables the instruction busy-time model.
// Rev    : 1.0  initial release
//============================================================================
module hd44780_responder
  import hd44780_pkg::*;
#(
  parameter int unsigned CMD_BUSY_CYCLES   = 10,
  parameter int unsigned CLEAR_BUSY_CYCLES = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic [3:0] db,
  output logic       busy,
  output logic       four_bit,
  output logic       func_n,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink,
  output logic       entry_id,
  output logic       entry_s,
  output logic [6:0] ac,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic [1:0] err,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  logic         e_q, rs_q;
  logic [3:0]   db_q;
  ctrl_t        ctrl_q, ctrl_d;
  logic [3:0]   hi_nib_q, hi_nib_d;
  logic         hi_rs_q, hi_rs_d;
  logic [1:0]   err_q, err_d;
  logic         byte_valid_q, byte_valid_d;
  logic [7:0]   byte_out_q, byte_out_d;
  logic         byte_rs_q, byte_rs_d;
  sweep_state_t state_q, state_d;
  logic [6:0]   sweep_addr_q, sweep_addr_d;

  logic         strobe, exec_byte, wr_en;
  logic [6:0]   wr_addr;
  logic [7:0]   wr_data, new_byte;
  ins_t         ins;

  assign strobe   = e_q & ~e;
  assign new_byte = ctrl_q.four_bit ? {hi_nib_q, db_q} : {db_q, 4'h0};
  assign ins      = decode_ins(new_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q          <= 1'b0;
      rs_q         <= 1'b0;
      db_q         <= 4'h0;
      ctrl_q       <= CTRL_RESET;
      hi_nib_q     <= 4'h0;
      hi_rs_q      <= 1'b0;
      err_q        <= 2'b00;
      byte_valid_q <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_rs_q    <= 1'b0;
      state_q      <= ST_SWEEP;
      sweep_addr_q <= 7'h00;
    end else begin
      e_q          <= e;
      rs_q         <= rs;
      db_q         <= db;
      ctrl_q       <= ctrl_d;
      hi_nib_q     <= hi_nib_d;
      hi_rs_q      <= hi_rs_d;
      err_q        <= err_d;
      byte_valid_q <= byte_valid_d;
      byte_out_q   <= byte_out_d;
      byte_rs_q    <= byte_rs_d;
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    hi_nib_d     = hi_nib_q;
    hi_rs_d      = hi_rs_q;
    err_d        = err_q;
    byte_valid_d = 1'b0;
    byte_out_d   = byte_out_q;
    byte_rs_d    = byte_rs_q;
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    exec_byte    = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = sweep_addr_q;
    wr_data      = BLANK_CHAR;

    if (state_q == ST_SWEEP) begin
      wr_en        = 1'b1;
      sweep_addr_d = sweep_addr_q + 7'd1;
      if (sweep_addr_q == SWEEP_LAST) state_d = ST_IDLE;
    end

    if (strobe) begin
      if (busy) begin
        err_d[0] = 1'b1;
      end else if (!ctrl_q.four_bit) begin
        exec_byte = 1'b1;
      end else if (!ctrl_q.phase_lo) begin
        hi_nib_d        = db_q;
        hi_rs_d         = rs_q;
        ctrl_d.phase_lo = 1'b1;
      end else begin
        ctrl_d.phase_lo = 1'b0;
        exec_byte       = 1'b1;
        if (rs_q != hi_rs_q) err_d[1] = 1'b1;
      end
    end

    // Busy is held through the sweep, so a data write never meets a sweep write.
    if (exec_byte) begin
      byte_valid_d = 1'b1;
      byte_out_d   = new_byte;
      byte_rs_d    = rs_q;
      if (rs_q) begin
        if (!ctrl_q.cg_mode) begin
          wr_en     = 1'b1;
          wr_addr   = ctrl_q.ac;
          wr_data   = new_byte;
          ctrl_d.ac = ac_step(ctrl_q.ac, ctrl_q.entry_id, ctrl_q.func_n);
        end
      end else begin
        unique case (ins)
          INS_CLEAR: begin
            state_d         = ST_SWEEP;
            sweep_addr_d    = 7'h00;
            ctrl_d.ac       = 7'h00;
            ctrl_d.entry_id = 1'b1;
          end
          INS_HOME:    ctrl_d.ac = 7'h00;
          INS_ENTRY:   {ctrl_d.entry_id, ctrl_d.entry_s} = new_byte[1:0];
          INS_DISPLAY: {ctrl_d.display_on, ctrl_d.cursor_on, ctrl_d.blink} = new_byte[2:0];
          INS_SHIFT: begin
            if (!new_byte[3]) ctrl_d.ac = ac_step(ctrl_q.ac, new_byte[2], ctrl_q.func_n);
          end
          INS_FUNC: begin
            ctrl_d.four_bit = ~new_byte[4];
            ctrl_d.phase_lo = 1'b0;
            ctrl_d.func_n   = new_byte[3];
          end
          INS_CGRAM: ctrl_d.cg_mode = 1'b1;
          INS_DDRAM: begin
            ctrl_d.ac      = new_byte[6:0];
            ctrl_d.cg_mode = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HD44780_RSP_BUSY_TIMING_EN
  localparam int unsigned BUSY_W = $clog2(CLEAR_BUSY_CYCLES + 1);
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              long_cmd;

  assign long_cmd = ~rs_q & ((ins == INS_CLEAR) | (ins == INS_HOME));

  always_comb begin
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - BUSY_W'(1) : '0;
    if (exec_byte) busy_cnt_d = long_cmd ? BUSY_W'(CLEAR_BUSY_CYCLES) : BUSY_W'(CMD_BUSY_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (rst) busy_cnt_q <= '0;
    else     busy_cnt_q <= busy_cnt_d;
  end

  assign busy = (state_q == ST_SWEEP) | (busy_cnt_q != '0);
`else
  logic unused_busy_params;
  assign unused_busy_params = (CMD_BUSY_CYCLES != 0) ^ (CLEAR_BUSY_CYCLES != 0);
  assign busy = (state_q == ST_SWEEP);
`endif

  hd44780_ddram u_ddram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign four_bit   = ctrl_q.four_bit;
  assign func_n     = ctrl_q.func_n;
  assign display_on = ctrl_q.display_on;
  assign cursor_on  = ctrl_q.cursor_on;
  assign blink      = ctrl_q.blink;
  assign entry_id   = ctrl_q.entry_id;
  assign entry_s    = ctrl_q.entry_s;
  assign ac         = ctrl_q.ac;
  assign err        = err_q;
  assign byte_valid = byte_valid_q;
  assign byte_out   = byte_out_q;
  assign byte_rs    = byte_rs_q;

endmodule
`default_nettype wire

// File: tb/tb_hd44780_responder.sv
`default_nettype none
//============================================================================
// Module : tb_hd44780_responder
// Brief  : Self-checking bench: vector table, directed corners, random bytes.
// Rev    : 1.0  initial release
//============================================================================
module tb_hd44780_responder;

`ifdef HD44780_RSP_BUSY_TIMING_EN
  localparam int EXP_CMD_BUSY = 10;
  localparam int EXP_CLR_BUSY = 400;
  localparam bit EXP_DROP     = 1'b1;
`else
  localparam int EXP_CMD_BUSY = 0;
  localparam int EXP_CLR_BUSY = 128;
  localparam bit EXP_DROP     = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, e = 1'b0, rs = 1'b0;
  logic [3:0] db = 4'h0;
  logic [6:0] rd_addr = 7'h00;
  logic       busy, four_bit, func_n, display_on, cursor_on, blink;
  logic       entry_id, entry_s, byte_valid, byte_rs;
  logic [6:0] ac;
  logic [7:0] byte_out, rd_data;
  logic [1:0] err;

  always #5 clk = ~clk;

  hd44780_responder dut (
    .clk(clk), .rst(rst), .e(e), .rs(rs), .db(db), .busy(busy),
    .four_bit(four_bit), .func_n(func_n), .display_on(display_on),
    .cursor_on(cursor_on), .blink(blink), .entry_id(entry_id),
    .entry_s(entry_s), .ac(ac), .byte_valid(byte_valid), .byte_out(byte_out),
    .byte_rs(byte_rs), .err(err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int tests = 0, fails = 0;

  // Reference model: display state as seen by a host, updated per accepted byte.
  logic [7:0] m_ram [128];
  logic       m_4bit, m_fn, m_d, m_c, m_b, m_id, m_s, m_cg;
  logic [6:0] m_ac;

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic [6:0] exp_ac;
  } vec_t;
  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
    m_4bit = 0; m_fn = 0; m_d = 0; m_c = 0; m_b = 0; m_id = 1; m_s = 0; m_cg = 0; m_ac = 0;
  endtask

  // Position along the visible line(s): 40+40 cells on two lines, 80 on one.
  function automatic logic [6:0] m_step(input logic [6:0] a, input logic up, input logic two);
    int pos;
    pos = (two && a >= 7'h40) ? int'(a) - 64 + 40 : int'(a);
    pos = (pos + (up ? 1 : 79)) % 80;
    if (two && pos >= 40) return 7'(pos - 40 + 64);
    return 7'(pos);
  endfunction

  task automatic m_apply(input logic r, input logic [7:0] b);
    if (r) begin
      if (!m_cg) begin
        m_ram[m_ac] = b;
        m_ac = m_step(m_ac, m_id, m_fn);
      end
    end
    else if (b >= 8'h80) begin m_ac = b[6:0]; m_cg = 0; end
    else if (b >= 8'h40) m_cg = 1;
    else if (b >= 8'h20) begin m_4bit = !b[4]; m_fn = b[3]; end
    else if (b >= 8'h10) begin if (!b[3]) m_ac = m_step(m_ac, b[2], m_fn); end
    else if (b >= 8'h08) begin m_d = b[2]; m_c = b[1]; m_b = b[0]; end
    else if (b >= 8'h04) begin m_id = b[1]; m_s = b[0]; end
    else if (b >= 8'h02) m_ac = 0;
    else if (b == 8'h01) begin
      for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
      m_ac = 0; m_id = 1;
    end
  endtask

  task automatic nib(input logic r, input logic [3:0] n);
    e = 1'b1; rs = r; db = n;
    @(negedge clk);
    e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("idle_wait_timeout", busy, 0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin n++; @(negedge clk); end
  endtask

  task automatic send_byte(input logic r, input logic [7:0] b);
    wait_idle();
    nib(r, b[7:4]);
    nib(r, b[3:0]);
    m_apply(r, b);
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] v);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic check_ram(input string name);
    logic [7:0] v;
    for (int i = 0; i < 128; i++) begin
      rd(7'(i), v);
      check(name, {i[7:0], v}, {i[7:0], m_ram[i]});
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got no completion, expected finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] v, b;

    vecs[0]  = '{1'b0, 8'hA7, 7'h27};  vecs[1]  = '{1'b1, 8'h5A, 7'h40};
    vecs[2]  = '{1'b0, 8'hE7, 7'h67};  vecs[3]  = '{1'b1, 8'h31, 7'h00};
    vecs[4]  = '{1'b0, 8'h04, 7'h00};  vecs[5]  = '{1'b1, 8'h32, 7'h67};
    vecs[6]  = '{1'b0, 8'h80, 7'h00};  vecs[7]  = '{1'b0, 8'h14, 7'h01};
    vecs[8]  = '{1'b0, 8'h10, 7'h00};  vecs[9]  = '{1'b0, 8'h10, 7'h67};
    vecs[10] = '{1'b0, 8'h18, 7'h67};  vecs[11] = '{1'b0, 8'h06, 7'h67};
    vecs[12] = '{1'b0, 8'h20, 7'h67};  vecs[13] = '{1'b0, 8'hCF, 7'h4F};
    vecs[14] = '{1'b1, 8'h55, 7'h00};  vecs[15] = '{1'b0, 8'h04, 7'h00};
    vecs[16] = '{1'b1, 8'h56, 7'h4F};  vecs[17] = '{1'b0, 8'h06, 7'h4F};
    vecs[18] = '{1'b0, 8'h28, 7'h4F};  vecs[19] = '{1'b0, 8'h40, 7'h4F};
    vecs[20] = '{1'b1, 8'h77, 7'h4F};  vecs[21] = '{1'b0, 8'h80, 7'h00};

    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    check("rst_four_bit", four_bit, 0);
    check("rst_flags", {func_n, display_on, cursor_on, blink, entry_id, entry_s}, 6'b000010);
    check("rst_ac", ac, 0);
    check("rst_err", err, 0);
    check("rst_byte", {byte_valid, byte_out, byte_rs}, 0);
    count_busy(n);
    check("rst_busy_cycles", n, 128);
    rd(7'h00, v); check("blank_00", v, 8'h20);
    rd(7'h40, v); check("blank_40", v, 8'h20);
    rd(7'h7F, v); check("blank_7F", v, 8'h20);

    // Host init: one 8-bit strobe, then 4-bit bytes.
    wait_idle();
    nib(1'b0, 4'h2);
    m_apply(1'b0, 8'h20);
    check("init8_byte", {byte_valid, byte_out}, {1'b1, 8'h20});
    check("init8_four_bit", four_bit, 1);
    send_byte(1'b0, 8'h28);
    count_busy(n);
    check("cmd_busy_cycles", n, EXP_CMD_BUSY);
    send_byte(1'b0, 8'h0E);
    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'h01);
    count_busy(n);
    check("clear_busy_cycles", n, EXP_CLR_BUSY);
    check("init_flags", {four_bit, func_n, display_on, cursor_on, blink, entry_id, entry_s},
          7'b1111010);
    check("init_ac_err", {ac, err}, 0);

    send_byte(1'b0, 8'hC0);
    send_byte(1'b1, 8'h41);
    check("data_pulse", {byte_valid, byte_out, byte_rs}, {1'b1, 8'h41, 1'b1});
    check("data_ac", ac, 7'h41);
    @(negedge clk);
    check("pulse_one_cycle", byte_valid, 0);
    rd(7'h40, v); check("ddram_40", v, 8'h41);

    for (int i = 0; i < 22; i++) begin
      send_byte(vecs[i].rs, vecs[i].b);
      check($sformatf("vec%0d_ac", i), ac, vecs[i].exp_ac);
      check($sformatf("vec%0d_byte", i), {byte_valid, byte_out, byte_rs},
            {1'b1, vecs[i].b, vecs[i].rs});
    end
    rd(7'h27, v); check("ddram_27", v, 8'h5A);

    for (int i = 0; i < 150; i++) begin
      logic r;
      r = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin r = 1'b1; b = 8'($urandom); end
        5: b = 8'h80 | ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h00) | 8'($urandom_range(0, 39));
        6: b = 8'h04 | 8'($urandom_range(0, 3));
        7: b = 8'h10 | 8'($urandom_range(0, 3) << 2);
        8: b = 8'h08 | 8'($urandom_range(0, 7));
        default: b = 8'h40 | 8'($urandom_range(0, 63));
      endcase
      send_byte(r, b);
      check("rnd_state", {ac, entry_id, entry_s, display_on, cursor_on, blink},
            {m_ac, m_id, m_s, m_d, m_c, m_b});
      check("rnd_byte", {byte_out, byte_rs}, {b, r});
    end
    send_byte(1'b0, 8'h80);

    // Second byte strobed right after the first.
    send_byte(1'b0, 8'h90);
    wait_idle();
    nib(1'b1, 4'h3); nib(1'b1, 4'h3);
    m_apply(1'b1, 8'h33);
    nib(1'b1, 4'h4); nib(1'b1, 4'h4);
    if (!EXP_DROP) m_apply(1'b1, 8'h44);
    check("drop_ac", ac, m_ac);
    check("drop_err0", err[0], EXP_DROP);
    rd(7'h11, v); check("drop_ddram_11", v, m_ram[17]);
    send_byte(1'b1, 8'h66);
    check("after_drop_ac", ac, m_ac);

    wait_idle();
    nib(1'b1, 4'h0); nib(1'b0, 4'h6);
    m_apply(1'b0, 8'h06);
    check("rs_mismatch_byte", {byte_out, byte_rs}, {8'h06, 1'b0});
    check("rs_mismatch_err", err, {1'b1, EXP_DROP});
    check_ram("ram_model");

    send_byte(1'b0, 8'h01);
    repeat (40) @(negedge clk);
    check("mid_sweep_busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    check("rerst_state", {four_bit, ac, err}, 0);
    count_busy(n);
    check("rerst_busy_cycles", n, 128);
    check_ram("ram_after_rerst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
